// File: rtl/count_step_checker.sv
// Observer for a free-running WIDTH-bit counter: checks every step is +1 mod 2^WIDTH,
// flags wraps and value matches, and keeps saturating wrap/error counts.
//
// state  | meaning
// INIT   | first sample after clr, captured without a step check
// TRACK  | stepping cleanly, each sample checked against q_prev+1
// FAULT  | sticky error raised, still tracking; err_clr on a legal step returns to TRACK
// 3      | unused encoding, recovers to INIT on the next edge
module count_step_checker #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  q_in,
  input  logic [WIDTH-1:0]  match_val,
  input  logic              err_clr,
  output logic              match,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [3:0]        err_cnt,
  output logic [1:0]        state
);

  localparam logic [1:0]        ST_INIT  = 2'd0;
  localparam logic [1:0]        ST_TRACK = 2'd1;
  localparam logic [1:0]        ST_FAULT = 2'd2;
  localparam logic [WIDTH-1:0]  Q_MAX    = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [3:0]        ERR_MAX  = 4'hF;

  logic [WIDTH-1:0]  q_prev;
  logic [WIDTH-1:0]  q_exp;
  logic              step_ok;
  logic              check_en;
  logic              legal_wrap;
  logic              step_err;
  logic [1:0]        state_nxt;
  logic              err_nxt;
  logic [WRAP_W-1:0] wrap_cnt_nxt;
  logic [3:0]        err_cnt_nxt;

  assign q_exp      = q_prev + 1'b1;
  assign step_ok    = (q_in == q_exp);
  assign check_en   = (state == ST_TRACK) || (state == ST_FAULT);
  assign legal_wrap = check_en && step_ok && (q_prev == Q_MAX);
  assign step_err   = check_en && !step_ok;

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    case (state)
      ST_INIT: state_nxt = ST_TRACK;
      ST_TRACK: begin
        if (step_err) begin
          state_nxt = ST_FAULT;
          err_nxt   = 1'b1;
        end
      end
      ST_FAULT: begin
        // a mismatch on the same edge as err_clr keeps the fault
        if (!step_err && err_clr) begin
          state_nxt = ST_TRACK;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    wrap_cnt_nxt = wrap_cnt;
    err_cnt_nxt  = err_cnt;
    if (legal_wrap && (wrap_cnt != WRAP_MAX)) wrap_cnt_nxt = wrap_cnt + 1'b1;
    if (step_err && (err_cnt != ERR_MAX))     err_cnt_nxt  = err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_INIT;
      q_prev   <= '0;
      match    <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      q_prev   <= q_in;
      match    <= (q_in == match_val);
      wrap     <= legal_wrap;
      wrap_cnt <= wrap_cnt_nxt;
      err      <= err_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

endmodule

// File: doc/count_step_checker.md
# count_step_checker

Downstream monitor for the 4-bit free-running `counter` stage. It samples the counter output `Q` every clock and checks that each step is exactly +1 modulo 2^WIDTH. It reports wrap-arounds, programmable value matches and step errors, and keeps saturating event counts. It sits on the same `clk`/`clr` as the counter and acts as a self-checking observer in the counter subsystem.

## Interface
- `WIDTH`, default 4: width of the monitored count.
- `WRAP_W`, default 8: width of the wrap counter.
- `clk` in 1: single clock; all logic is rising-edge.
- `clr` in 1: synchronous, active-high reset. Same net that drives the counter's `clr`.
- `q_in` in WIDTH: counter output `Q`, sampled every `clk`.
- `match_val` in WIDTH: compare value; quasi-static.
- `err_clr` in 1: request to clear the sticky error; level-sampled.
- `match` out 1: one-cycle pulse when the sampled `q_in` equals `match_val`.
- `wrap` out 1: one-cycle pulse on a legal step from 2^WIDTH-1 to 0.
- `wrap_cnt` out WRAP_W: number of wraps, saturating.
- `err` out 1: sticky step-error flag.
- `err_cnt` out 4: number of step errors, saturating at 15.
- `state` out 2: monitor state, INIT=0, TRACK=1, FAULT=2.

## Operation
- Internal register `q_prev` (WIDTH bits) holds the last sample. Expected next value is `q_prev+1`, truncated to WIDTH bits, so 15 wraps to 0.
- **Reset** (`clr`=1 at an edge): `state`=INIT, `q_prev`=0. Every output is 0, including `match`, `wrap`, `wrap_cnt`, `err`, `err_cnt` and `state`. Reset has priority over all other inputs.
- **INIT:**
  - On the first edge with `clr`=0: `q_prev`←`q_in`, go to TRACK.
  - No step check, so no `wrap` and no `err`.
  - `match` is still evaluated.
- **TRACK:**
  - Every edge: `q_prev`←`q_in`.
  - If `q_in`==expected and `q_prev`==2^WIDTH-1: `wrap`=1 and `wrap_cnt`+1, saturating at 2^WRAP_W-1. `wrap` still pulses once saturated.
  - If `q_in`≠expected, including a repeated value (a hold): `err`←1, `err_cnt`+1 (saturating), go to FAULT. No `wrap` on that edge.
- **FAULT:**
  - `q_prev` keeps tracking, so the next check is relative to the faulty sample.
  - Legal wraps are still counted; further mismatches still increment `err_cnt`.
  - If `err_clr`=1 and the current step is legal: `err`←0, go to TRACK.
  - If `err_clr`=1 and the current step is a mismatch: the mismatch wins. `err` stays 1, `err_cnt` increments, state stays FAULT.
- **Match:** `match`←(`q_in`==`match_val`) on every non-reset edge, in any state.
- `err_clr` in INIT or TRACK has no effect.
- `state` encoding 3 is unused. If it is ever reached, the next edge goes to INIT.

## Timing
- All outputs are registered. `match`, `wrap` and `err` rise on the edge that samples the triggering `q_in`, i.e. one cycle after the counter presents that value.
- `wrap` and `match` are single-cycle pulses. `err` stays high until cleared.
- After `clr` falls: the first edge performs the INIT capture. The first step check happens on the second edge.
- A legal counter restarting from 0 after a shared `clr` produces no error.
- Asserting `clr` mid-run, e.g. at `q_in`=7, gives all-zero outputs on the next edge. The counter's 7→0 jump is not checked and produces neither `wrap` nor `err`.
- `wrap_cnt` and `err_cnt` update on the same edge as their pulse or flag.

## Test plan
1. Shared `clr` for 1 cycle, counter free-running with 10 ns period, 17 steps (0..15 then 0) → exactly one `wrap` pulse, on the edge sampling 15→0. `wrap_cnt`=1, `err`=0, `state`=1.
2. `match_val`=9, free-run 48 cycles → `match` pulses exactly 3 times, each one cycle after `q_in`=9, spaced 16 cycles apart. No other `match` pulses.
3. Force `q_in` sequence 3, 5, 6, 7 → `err`=1 and `err_cnt`=1 after 5, `state`=2. No further increment for 6 and 7.
4. In FAULT: `err_clr`=1 with a legal step 7→8 → `err`=0, `state`=1. Then force 8→8 with `err_clr`=1 in the same cycle → `err`=1, `err_cnt`=2, `state`=2.
5. Saturation: 300 legal wraps → `wrap_cnt`=255 and `wrap` still pulses. Then 20 forced mismatches → `err_cnt`=15.
6. `clr`=1 mid-run at `q_in`=7 with `err`=1 and `wrap_cnt`=4 → next edge all outputs 0, `state`=0. Counter resumes from 0 → no `err`, and the first `wrap` after 16 steps gives `wrap_cnt`=1.
